patmos_reset_ctrl: RTL

- Reset controller directly upstream of the Patmos core's reset input.
- Synchronises the board reset and debounces the external reset button.
- Stretches every reset to a minimum hold time.
- Drives a clean active-high core reset with synchronous deassertion, and records the reset cause for software/LED debug.

---
 rtl/patmos_reset_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/patmos_reset_ctrl.sv
// rtl/patmos_reset_ctrl.sv - reset synchroniser, button debounce and reset stretcher for the Patmos core
//
// Purpose:
//   Produces the active-high core reset. The board reset and the reset button
//   are synchronised, the button is debounced, and every reset is held for at
//   least HOLD_CYCLES after its source clears. The last reset cause and a
//   saturating count of button resets are kept for software/LED debug.
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-low board / power-on reset
//   btn_in         in   raw asynchronous reset button (polarity per BTN_ACTIVE_HIGH)
//   pll_locked     in   PLL lock, asynchronous, active-high (RESET_CTRL_LOCK_MON_EN only)
//   core_reset     out  active-high core reset, asserts async, deasserts sync
//   rst_cause      out  01 POR, 10 button, 11 lock loss
//   btn_reset_cnt  out  saturating count of button-initiated resets
//
// Optional feature macro: RESET_CTRL_LOCK_MON_EN (adds pll_locked monitoring).

module patmos_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
`ifdef RESET_CTRL_LOCK_MON_EN
    input  logic       pll_locked,
`endif
    output logic       core_reset,
    output logic [1:0] rst_cause,
    output logic [7:0] btn_reset_cnt
);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PRESS = 2'd2
    } state_e;

    localparam logic [1:0]  CAUSE_POR  = 2'b01;
    localparam logic [1:0]  CAUSE_BTN  = 2'b10;
    localparam logic [1:0]  CAUSE_LOCK = 2'b11;

    localparam logic [15:0] DB_MAX   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_MAX = 8'(HOLD_CYCLES - 1);
    // The PRESS cycle in which the debounced button is already released counts
    // as the first hold cycle, so a button reset is stretched exactly like POR.
    localparam logic [7:0]  HOLD_ENTRY = (HOLD_CYCLES > 1) ? 8'd1 : 8'd0;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
    logic                   rst_n_s;
    logic                   btn_norm;
    logic                   btn_s;
    logic                   locked_s;
    logic                   lock_lost;

    assign btn_norm = BTN_ACTIVE_HIGH ? btn_in : ~btn_in;
    assign rst_n_s  = rst_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];

    always_comb begin
        rst_sync_d = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
        btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_norm};
    end

`ifdef RESET_CTRL_LOCK_MON_EN
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic                   lock_prev_q, lock_prev_d;

    assign locked_s  = lock_sync_q[SYNC_STAGES-1];
    // Only a falling edge counts as loss; lock never achieved is handled by
    // HOLD refusing to exit while unlocked.
    assign lock_lost = lock_prev_q & ~locked_s;

    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        lock_prev_d = locked_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_sync_q <= '0;
            lock_prev_q <= 1'b0;
        end else begin
            lock_sync_q <= lock_sync_d;
            lock_prev_q <= lock_prev_d;
        end
    end
`else
    assign locked_s  = 1'b1;
    assign lock_lost = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Button debounce
    // ------------------------------------------------------------------
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        btn_db_q, btn_db_d;

    always_comb begin
        btn_db_d = btn_db_q;
        db_cnt_d = '0;
        if (!rst_n_s) begin
            btn_db_d = 1'b0;
            db_cnt_d = '0;
        end else if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_MAX) begin
                btn_db_d = ~btn_db_q;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reset FSM
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  rst_cause_q, rst_cause_d;
    logic [7:0]  btn_reset_cnt_q, btn_reset_cnt_d;
    logic        core_reset_q, core_reset_d;

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        rst_cause_d     = rst_cause_q;
        btn_reset_cnt_d = btn_reset_cnt_q;

        if (!rst_n_s) begin
            state_d         = ST_HOLD;
            hold_cnt_d      = '0;
            rst_cause_d     = CAUSE_POR;
            btn_reset_cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (lock_lost) begin
                        hold_cnt_d  = '0;
                        rst_cause_d = CAUSE_LOCK;
                    end else if (btn_db_q) begin
                        state_d = ST_PRESS;
                    end else if (!locked_s) begin
                        // The hold time is measured from lock returning.
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_MAX) begin
                        // A press still being debounced keeps us here, so a
                        // button held through power-on never releases the core.
                        if (!btn_s) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end

                ST_RUN: begin
                    if (lock_lost) begin
                        state_d     = ST_HOLD;
                        hold_cnt_d  = '0;
                        rst_cause_d = CAUSE_LOCK;
                    end else if (btn_db_q) begin
                        state_d     = ST_PRESS;
                        rst_cause_d = CAUSE_BTN;
                        if (btn_reset_cnt_q != 8'hFF) begin
                            btn_reset_cnt_d = btn_reset_cnt_q + 8'd1;
                        end
                    end
                end

                ST_PRESS: begin
                    if (lock_lost) begin
                        state_d     = ST_HOLD;
                        hold_cnt_d  = '0;
                        rst_cause_d = CAUSE_LOCK;
                    end else if (!btn_db_q) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = HOLD_ENTRY;
                    end
                end

                default: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            endcase
        end

        // Registered from the next state so the output is glitch-free.
        core_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q      <= '0;
            btn_sync_q      <= '0;
            db_cnt_q        <= '0;
            btn_db_q        <= 1'b0;
            state_q         <= ST_HOLD;
            hold_cnt_q      <= '0;
            rst_cause_q     <= CAUSE_POR;
            btn_reset_cnt_q <= '0;
            core_reset_q    <= 1'b1;
        end else begin
            rst_sync_q      <= rst_sync_d;
            btn_sync_q      <= btn_sync_d;
            db_cnt_q        <= db_cnt_d;
            btn_db_q        <= btn_db_d;
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            rst_cause_q     <= rst_cause_d;
            btn_reset_cnt_q <= btn_reset_cnt_d;
            core_reset_q    <= core_reset_d;
        end
    end

    assign core_reset    = core_reset_q;
    assign rst_cause     = rst_cause_q;
    assign btn_reset_cnt = btn_reset_cnt_q;

endmodule
